// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency ROM requests and
// buffers returned {inst, pc} pairs in a DEPTH-entry FIFO feeding decode.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = 4,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            rom_req_o,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic [XLEN-1:0] rom_inst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [CW-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [XLEN-1:0] pc, inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            pop, push;
  logic [CW:0]     credit;

  assign valid_o = (count != '0) & ~redirect_i;
  assign pop     = valid_o & ready_i;
  assign push    = inflight & ~redirect_i;

  // Slots already committed (stored + in flight), minus the one leaving this cycle.
  assign credit    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign rom_req_o = ~rst_i & ~redirect_i & (credit < (CW+1)'(DEPTH));

  assign rom_addr_o = pc;
  assign count_o    = count;
  assign inst_o     = valid_o ? mem[rd_ptr].inst : NOP_INST;
  assign pc_o       = valid_o ? mem[rd_ptr].pc   : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_i) begin
      // Pending response and buffered entries belong to the wrong path.
      pc       <= redirect_pc_i;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= rom_req_o;
      if (rom_req_o) begin
        inflight_pc <= pc;
        pc          <= pc + PC_STEP;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= '{inst: rom_inst_i, pc: inflight_pc};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue; a second instance covers PC wrap-around.
module tb_fetch_queue;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic        rst = 1, rdy = 1, rdr = 0;
  logic [31:0] rpc = '0;
  logic        req, vld;
  logic [31:0] addr, rinst, inst, pc;
  logic [2:0]  cnt;

  fetch_queue dut (
    .clk_i(clk), .rst_i(rst), .rom_req_o(req), .rom_addr_o(addr), .rom_inst_i(rinst),
    .redirect_i(rdr), .redirect_pc_i(rpc), .inst_o(inst), .pc_o(pc), .valid_o(vld),
    .ready_i(rdy), .count_o(cnt));

  // ROM content is addr ^ K so instructions differ from their PCs
  always @(posedge clk) rinst <= addr ^ K;

  // wrap instance
  logic        rst_b = 1, rdy_b = 1, rdr_b = 0;
  logic [31:0] rpc_b = '0;
  logic        req_b, vld_b;
  logic [31:0] addr_b, rinst_b, inst_b, pc_b;
  logic [2:0]  cnt_b;

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .rom_req_o(req_b), .rom_addr_o(addr_b), .rom_inst_i(rinst_b),
    .redirect_i(rdr_b), .redirect_pc_i(rpc_b), .inst_o(inst_b), .pc_o(pc_b), .valid_o(vld_b),
    .ready_i(rdy_b), .count_o(cnt_b));

  always @(posedge clk) rinst_b <= addr_b ^ K;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rdy, rdr;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t tv [NV];

  initial begin
    //          rst   rdy   rdr   rpc           req   addr          vld   pc            cnt
    // reset state, then streaming with ready=1
    tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        3'd0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        3'd0};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0,        3'd1};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4,        3'd1};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h8,        3'd1};
    // reset again, then fill with ready=0 until credit is exhausted
    tv[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h14,       1'b1, 32'hC,        3'd1};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        3'd0};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        3'd0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0,        3'd1};
    tv[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h0,        3'd2};
    tv[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 32'h0,        3'd3};
    tv[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 32'h0,        3'd4};
    tv[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10,       1'b1, 32'h0,        3'd4};
    // ready returns: issue resumes the same cycle, entries drain in order
    tv[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h0,        3'd4};
    tv[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'h4,        3'd3};
    tv[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 32'h8,        3'd3};
    tv[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 32'hC,        3'd3};
    tv[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 32'h10,       3'd3};
    // redirect with 3 stored + 1 in flight, coincident with pop and push
    tv[19] = '{1'b0, 1'b1, 1'b1, 32'h100,      1'b0, 32'h24,       1'b0, 32'h0,        3'd3};
    tv[20] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,        3'd0};
    tv[21] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b0, 32'h0,        3'd0};
    tv[22] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 32'h100,      3'd1};
    tv[23] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10C,      1'b1, 32'h104,      3'd1};
    // build up to full credit, then reset with a request in flight
    tv[24] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h110,      1'b1, 32'h108,      3'd1};
    tv[25] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h114,      1'b1, 32'h108,      3'd2};
    tv[26] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h118,      1'b1, 32'h108,      3'd3};
    tv[27] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        3'd0};
    tv[28] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        3'd0};
    tv[29] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0,        3'd1};

    repeat (2) @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst; rdy = tv[i].rdy; rdr = tv[i].rdr; rpc = tv[i].rpc;
      #2;
      chk("rom_req", i, 32'(req), 32'(tv[i].req));
      chk("rom_addr", i, addr, tv[i].addr);
      chk("valid", i, 32'(vld), 32'(tv[i].vld));
      chk("pc", i, pc, tv[i].pc);
      chk("inst", i, inst, tv[i].vld ? (tv[i].pc ^ K) : NOP);
      chk("count", i, 32'(cnt), 32'(tv[i].cnt));
      @(negedge clk);
    end
    rst = 0; rdy = 1; rdr = 0;

    // PC wrap: first valid exactly two cycles after reset release
    begin
      logic [31:0] exp_pc [4];
      int n;
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000; exp_pc[3] = 32'h0000_0004;
      rst_b = 0; rdy_b = 1;
      n = 0;
      #2;
      while (!vld_b && n < 10) begin
        @(negedge clk); #2; n++;
      end
      chk("wrap_latency", 0, n, 2);
      for (int k = 0; k < 4; k++) begin
        chk("wrap_valid", k, 32'(vld_b), 32'h1);
        chk("wrap_pc", k, pc_b, exp_pc[k]);
        chk("wrap_inst", k, inst_b, exp_pc[k] ^ K);
        chk("wrap_count", k, 32'(cnt_b), 32'h1);
        @(negedge clk); #2;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
